// File: rtl/pe_row_seq.sv
// PE row sequencer: queues config words, strobes them into PEs/LSU, then runs.
// Optional abort support is compiled in with `define PE_ROW_SEQ_ABORT_EN.
module pe_row_seq #(
  parameter int NUM_PE     = 4,
  parameter int INST_W     = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int RUN_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_target,
  input  logic [INST_W-1:0] cfg_data,
  input  logic              start,
  input  logic [NUM_PE:0]   run_mask,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic              abort,
  output logic [NUM_PE:0]   init_en_o,
  output logic [INST_W-1:0] inst_o,
  output logic [NUM_PE:0]   run_en_o,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err_target
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NU = NUM_PE + 1;
  localparam logic [4:0] MAX_T = 5'(NUM_PE);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [INST_W-1:0] mem_data [FIFO_DEPTH];
  logic [3:0]        mem_tgt  [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic [NUM_PE:0]   mask;
  logic [RUN_W-1:0]  cycles_cap, cnt;
  logic              push, pop, empty, abort_hit;

`ifdef PE_ROW_SEQ_ABORT_EN
  assign abort_hit = abort && (state == LOAD || state == RUN);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit = 1'b0;
  assign aborted = 1'b0;
`endif

  assign empty = (count == '0);
  assign push  = cfg_valid && cfg_ready;
  assign pop   = (state == LOAD) && !empty && !abort_hit;

  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
    if (abort_hit)
      count_nxt = '0;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (abort_hit)
          state_nxt = DONE;
        else if (empty)
          state_nxt = (cycles_cap != '0) ? RUN : DONE;
      end
      RUN:  if (abort_hit || cnt == RUN_W'(1)) state_nxt = DONE;
      DONE: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= cfg_data;
      mem_tgt[wr_ptr]  <= cfg_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mask       <= '0;
      cycles_cap <= '0;
      cnt        <= '0;
      cfg_ready  <= 1'b0;
      init_en_o  <= '0;
      inst_o     <= '0;
      run_en_o   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_target <= 1'b0;
`ifdef PE_ROW_SEQ_ABORT_EN
      aborted    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      cfg_ready <= (count_nxt != CW'(FIFO_DEPTH)) &&
                   (state_nxt == IDLE || state_nxt == LOAD);
      init_en_o <= '0;
      if (abort_hit) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            mask       <= run_mask;
            cycles_cap <= run_cycles;
            err_target <= 1'b0;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (pop) begin
            inst_o <= mem_data[rd_ptr];
            if ({1'b0, mem_tgt[rd_ptr]} <= MAX_T)
              init_en_o <= NU'(1) << mem_tgt[rd_ptr];
            else
              err_target <= 1'b1;
          end
          if (state_nxt == RUN) begin
            run_en_o <= mask;
            cnt      <= cycles_cap;
          end
          if (state_nxt == DONE)
            done <= !abort_hit;
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (state_nxt == DONE) begin
            run_en_o <= '0;
            done     <= !abort_hit;
          end
        end
        DONE: begin
          if (done) begin
            done <= 1'b0;
            busy <= 1'b0;
`ifdef PE_ROW_SEQ_ABORT_EN
            aborted <= 1'b0;
          end else begin
            // Aborted entry: enables already dropped, report one cycle later.
            done    <= 1'b1;
            aborted <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule
